// File: rtl/bcd_share_arbiter.sv
// One binary-to-BCD converter shared by NREQ requesters through a round-robin grant.
// Each accepted value produces one response carrying the tens/ones digits and the owner ID.

module bin_to_bcd (
  input  logic [6:0] bin_i,
  output logic [1:0] hund_o,
  output logic [3:0] tens_o,
  output logic [3:0] ones_o
);

  // Double-dabble layout: hundreds [16:15], tens [14:11], ones [10:7], binary [6:0].
  logic [16:0] sr;

  always_comb begin
    sr = {10'd0, bin_i};
    for (int unsigned i = 0; i < 7; i++) begin
      if (sr[10:7] >= 4'd5)
        sr[10:7] = sr[10:7] + 4'd3;
      if (sr[14:11] >= 4'd5)
        sr[14:11] = sr[14:11] + 4'd3;
      sr = sr << 1;
    end
  end

  assign hund_o = sr[16:15];
  assign tens_o = sr[14:11];
  assign ones_o = sr[10:7];

endmodule

module bcd_share_arbiter #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [7*NREQ-1:0] req_num,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [3:0]        rsp_tens,
  output logic [3:0]        rsp_ones,
  output logic              rsp_ovf,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    RESP
  } state_t;

  localparam logic [IDW-1:0] LAST = IDW'(NREQ - 1);

  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [6:0]     num_q, num_d;
  logic [3:0]     tens_q, tens_d;
  logic [3:0]     ones_q, ones_d;
  logic           ovf_q, ovf_d;
  logic           busy_q;

  logic           found;
  logic [IDW-1:0] win;
  logic [IDW-1:0] scan;
  logic           grant;

  logic [1:0]     bcd_hund;
  logic [3:0]     bcd_tens;
  logic [3:0]     bcd_ones;

  bin_to_bcd u_bin_to_bcd (
    .bin_i  (num_q),
    .hund_o (bcd_hund),
    .tens_o (bcd_tens),
    .ones_o (bcd_ones)
  );

  // Scan starts at the pointer and wraps explicitly so non-power-of-two NREQ works.
  always_comb begin
    found = 1'b0;
    win   = '0;
    scan  = ptr_q;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && req_valid[scan]) begin
        found = 1'b1;
        win   = scan;
      end
      scan = (scan == LAST) ? '0 : scan + 1'b1;
    end
  end

  // Gated by rst so a reset cycle never hands out a grant that would be dropped.
  assign grant = found && (state_q == IDLE) && !rst;

  always_comb begin
    req_ready = '0;
    if (grant)
      req_ready[win] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    num_d   = num_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (grant) begin
          num_d   = req_num[int'(win)*7 +: 7];
          id_d    = win;
          ptr_d   = (win == LAST) ? '0 : win + 1'b1;
          state_d = CONV;
        end
      end
      CONV: begin
        // A non-zero hundreds digit is exactly the value > 99 case.
        ovf_d   = (bcd_hund != 2'd0);
        tens_d  = ovf_d ? 4'd9 : bcd_tens;
        ones_d  = ovf_d ? 4'd9 : bcd_ones;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      num_q   <= '0;
      tens_q  <= '0;
      ones_q  <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      num_q   <= num_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      ovf_q   <= ovf_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = id_q;
  assign rsp_tens  = tens_q;
  assign rsp_ones  = ones_q;
  assign rsp_ovf   = ovf_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_bcd_share_arbiter.sv
// Directed bench for bcd_share_arbiter: reset, latency, round-robin order, saturation, mid-flight reset.
// Inputs change 1 ns after posedge; outputs are sampled on negedge.

module tb_bcd_share_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [27:0] req_num;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [3:0]  rsp_tens;
  logic [3:0]  rsp_ones;
  logic        rsp_ovf;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  int t3_tens[4] = '{1, 9, 0, 4};
  int t3_ones[4] = '{0, 9, 0, 2};

  bcd_share_arbiter #(.NREQ(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_num   (req_num),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_tens  (rsp_tens),
    .rsp_ones  (rsp_ones),
    .rsp_ovf   (rsp_ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got %0d compared %0d mismatched", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  function automatic int idx_of(input logic [3:0] v);
    for (int i = 0; i < 4; i++)
      if (v[i]) return i;
    return -1;
  endfunction

  // Starts in sample phase, returns in sample phase with the block idle.
  task automatic drain();
    for (int k = 0; k < 8; k++) begin
      cyc();
      rsp_ready = 1'b1;
      smp();
      if (!busy && !rsp_valid) break;
    end
    chk("drain_idle", busy, 0);
    rsp_ready = 1'b0;
  endtask

  // Starts in drive phase, returns in sample phase.
  task automatic run_single(input int id, input int num, input int et, input int eo,
                            input int eovf, input string tag);
    bit got;
    req_num[id*7 +: 7] = 7'(num);
    req_valid[id] = 1'b1;
    rsp_ready = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 10; k++) begin
      smp();
      if (req_ready != 4'd0) begin
        got = 1'b1;
        break;
      end
      cyc();
    end
    chk({tag, "_grant"}, req_ready, 32'd1 << id);
    cyc();
    req_valid[id] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      smp();
      if (rsp_valid) break;
      cyc();
    end
    chk({tag, "_valid"}, rsp_valid, 1);
    chk({tag, "_id"},    rsp_id,    id);
    chk({tag, "_tens"},  rsp_tens,  et);
    chk({tag, "_ones"},  rsp_ones,  eo);
    chk({tag, "_ovf"},   rsp_ovf,   eovf);
    cyc();
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    smp();
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int ng, nr, lastc, w;
    logic [3:0] drop;

    // 1: reset with everyone requesting
    rst       = 1'b1;
    req_valid = 4'hF;
    req_num   = '0;
    rsp_ready = 1'b0;
    cyc();
    cyc();
    smp();
    chk("t1_rst_ready", req_ready, 0);
    chk("t1_rst_valid", rsp_valid, 0);
    chk("t1_rst_busy",  busy,      0);
    chk("t1_rst_id",    rsp_id,    0);
    chk("t1_rst_tens",  rsp_tens,  0);
    chk("t1_rst_ones",  rsp_ones,  0);
    chk("t1_rst_ovf",   rsp_ovf,   0);
    cyc();
    rst = 1'b0;
    smp();
    chk("t1_first_grant", req_ready, 4'b0001);
    cyc();
    req_valid = 4'h0;
    smp();
    drain();

    // 2: single request, response held while consumer stalls
    cyc();
    req_num[6:0] = 7'd57;
    req_valid = 4'b0001;
    rsp_ready = 1'b0;
    smp();
    chk("t2_grant", req_ready, 4'b0001);
    cyc();
    req_valid = 4'b0000;
    smp();
    chk("t2_conv_ready", req_ready, 0);
    chk("t2_conv_valid", rsp_valid, 0);
    chk("t2_conv_busy",  busy,      1);
    for (int k = 0; k < 3; k++) begin
      cyc();
      smp();
      chk("t2_rsp_valid", rsp_valid, 1);
      chk("t2_rsp_id",    rsp_id,    0);
      chk("t2_rsp_tens",  rsp_tens,  5);
      chk("t2_rsp_ones",  rsp_ones,  7);
      chk("t2_rsp_ovf",   rsp_ovf,   0);
    end
    cyc();
    rsp_ready = 1'b1;
    smp();
    chk("t2_accept_valid", rsp_valid, 1);
    cyc();
    rsp_ready = 1'b0;
    smp();
    chk("t2_after_valid", rsp_valid, 0);
    chk("t2_after_busy",  busy,      0);

    // 3: all four requesting from pointer 0, consumer always ready
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    req_num   = {7'd42, 7'd0, 7'd99, 7'd10};
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    drop = '0; ng = 0; nr = 0; lastc = 0;
    for (int c = 0; c < 30; c++) begin
      smp();
      if (req_ready != 4'd0) begin
        w = idx_of(req_ready);
        chk("t3_order", w, ng);
        chk("t3_onehot", $countones(req_ready), 1);
        if (ng > 0) chk("t3_spacing", c - lastc, 3);
        lastc = c;
        ng++;
        drop[w] = 1'b1;
      end
      if (rsp_valid) begin
        chk("t3_rsp_id",   rsp_id,   nr);
        chk("t3_rsp_tens", rsp_tens, t3_tens[rsp_id]);
        chk("t3_rsp_ones", rsp_ones, t3_ones[rsp_id]);
        nr++;
      end
      if (nr == 4) break;
      cyc();
      req_valid = req_valid & ~drop;
      drop = '0;
    end
    chk("t3_rsp_count", nr, 4);

    // 4: requesters 0 and 2 held continuously; pointer wrapped to 0 after grant 3
    cyc();
    req_num   = {7'd0, 7'd77, 7'd0, 7'd5};
    req_valid = 4'b0101;
    ng = 0;
    for (int c = 0; c < 40; c++) begin
      smp();
      if (req_ready != 4'd0) begin
        chk("t4_order", idx_of(req_ready), (ng % 2) ? 2 : 0);
        ng++;
        if (ng == 6) break;
      end
      cyc();
    end
    chk("t4_grant_count", ng, 6);
    cyc();
    req_valid = 4'b0000;
    smp();
    drain();

    // 5: saturation boundary
    cyc();
    run_single(1, 100, 9, 9, 1, "t5_100");
    cyc();
    run_single(1, 105, 9, 9, 1, "t5_105");
    cyc();
    run_single(1, 99, 9, 9, 0, "t5_99");
    cyc();
    run_single(3, 64, 6, 4, 0, "t5_64");

    // 6: reset while a response is waiting
    cyc();
    req_num[20:14] = 7'd33;
    req_valid = 4'b0100;
    rsp_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      smp();
      if (req_ready != 4'd0) break;
      cyc();
    end
    chk("t6_grant", req_ready, 4'b0100);
    cyc();
    req_valid = 4'b0000;
    for (int k = 0; k < 10; k++) begin
      smp();
      if (rsp_valid) break;
      cyc();
    end
    chk("t6_pre_valid", rsp_valid, 1);
    chk("t6_pre_tens",  rsp_tens,  3);
    chk("t6_pre_id",    rsp_id,    2);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    smp();
    chk("t6_valid", rsp_valid, 0);
    chk("t6_busy",  busy,      0);
    chk("t6_id",    rsp_id,    0);
    chk("t6_tens",  rsp_tens,  0);
    chk("t6_ones",  rsp_ones,  0);
    chk("t6_ready", req_ready, 0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      smp();
      chk("t6_no_stale_valid", rsp_valid, 0);
      chk("t6_no_stale_busy",  busy,      0);
    end
    cyc();
    req_valid = 4'hF;
    smp();
    chk("t6_ptr0", req_ready, 4'b0001);
    cyc();
    req_valid = 4'h0;
    smp();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
